// File: rtl/wave_capture_multi.sv
// Multi-channel wave capture: decimates a packed sample stream and writes one
// triggered frame per channel into the write half of a ping-pong sample RAM.
module wave_capture_multi #(
  parameter int CHANNELS   = 2,
  parameter int SAMPLE_W   = 16,
  parameter int OUT_W      = 8,
  parameter int DEPTH_LOG2 = 9,
  localparam int TRIG_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         new_sample,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample,
  input  logic [2:0]                   decim,
  input  logic [TRIG_W-1:0]            trig_ch,
  input  logic [1:0]                   trig_mode,
  input  logic                         wave_display_idle,
  output logic                         write_enable,
  output logic [DEPTH_LOG2:0]          write_address,
  output logic [CHANNELS*OUT_W-1:0]    write_sample,
  output logic                         read_index,
  output logic                         frame_done,
  output logic [1:0]                   state
);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t                      st;
  logic [7:0]                  dcnt;
  logic [2:0]                  decim_cur;
  logic [7:0]                  dlim;
  logic                        accept;
  logic [DEPTH_LOG2-1:0]       idx;
  logic                        prev_neg;
  logic                        prev_valid;
  logic [SAMPLE_W-1:0]         trig_s;
  logic                        cur_neg;
  logic                        is_trig;
  logic [CHANNELS*OUT_W-1:0]   conv;

  assign state = st;

  // new_sample is a strobe with no back-pressure: the sample is consumed on
  // every cycle it is high, and an accepted strobe yields a write one cycle later.
  assign dlim   = (8'd1 << decim_cur) - 8'd1;
  assign accept = new_sample && (dcnt == 8'd0);

  // The period starting at an accepted strobe uses the decim seen at that strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt      <= 8'd0;
      decim_cur <= 3'd0;
    end else if (new_sample) begin
      if (dcnt == 8'd0) begin
        decim_cur <= decim;
        dcnt      <= (decim == 3'd0) ? 8'd0 : 8'd1;
      end else if (dcnt >= dlim) begin
        dcnt <= 8'd0;
      end else begin
        dcnt <= dcnt + 8'd1;
      end
    end
  end

  always_comb begin
    trig_s = sample[0 +: SAMPLE_W];
    for (int c = 1; c < CHANNELS; c++) begin
      if (trig_ch == TRIG_W'(c)) trig_s = sample[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  assign cur_neg = trig_s[SAMPLE_W-1];

  always_comb begin
    conv = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      conv[c*OUT_W +: OUT_W] = {~sample[c*SAMPLE_W + SAMPLE_W - 1],
                                sample[c*SAMPLE_W + SAMPLE_W - 2 -: OUT_W - 1]};
    end
  end

  always_comb begin
    case (trig_mode)
      2'd0:    is_trig = 1'b1;
      2'd1:    is_trig = prev_valid && prev_neg && !cur_neg;
      2'd2:    is_trig = prev_valid && !prev_neg && cur_neg;
      default: is_trig = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st            <= ARMED;
      idx           <= '0;
      write_enable  <= 1'b0;
      write_address <= {1'b1, {DEPTH_LOG2{1'b0}}};
      write_sample  <= '0;
      read_index    <= 1'b0;
      frame_done    <= 1'b0;
      prev_neg      <= 1'b0;
      prev_valid    <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      frame_done   <= 1'b0;
      if (accept) begin
        prev_neg   <= cur_neg;
        prev_valid <= 1'b1;
      end
      case (st)
        ARMED: begin
          if (accept && is_trig) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, {DEPTH_LOG2{1'b0}}};
            write_sample  <= conv;
            idx           <= DEPTH_LOG2'(1);
            st            <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (accept) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, idx};
            write_sample  <= conv;
            idx           <= idx + DEPTH_LOG2'(1);
            if (idx == {DEPTH_LOG2{1'b1}}) st <= WAIT;
          end
        end
        WAIT: begin
          // Swap only while the display is idle so it never sees a torn frame.
          if (wave_display_idle) begin
            read_index    <= ~read_index;
            frame_done    <= 1'b1;
            idx           <= '0;
            write_address <= {read_index, {DEPTH_LOG2{1'b0}}};
            st            <= ARMED;
          end
        end
        default: st <= ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture_multi.sv
// Bench for wave_capture_multi: table-driven strobe vectors feed an expected
// write queue that a negedge monitor drains, plus hand-written swap/reset cases.
module tb_wave_capture_multi;

  localparam int CH = 2;
  localparam int SW = 16;
  localparam int OW = 8;
  localparam int DL = 4;

  logic              clk;
  logic              reset;
  logic              new_sample;
  logic [CH*SW-1:0]  sample;
  logic [2:0]        decim;
  logic [0:0]        trig_ch;
  logic [1:0]        trig_mode;
  logic              wave_display_idle;
  logic              write_enable;
  logic [DL:0]       write_address;
  logic [CH*OW-1:0]  write_sample;
  logic              read_index;
  logic              frame_done;
  logic [1:0]        state;

  typedef struct {
    logic signed [15:0] ch0;
    logic signed [15:0] ch1;
    bit                 wr;
    logic [DL-1:0]      idx;
  } vec_t;

  vec_t vec[80];
  logic [DL+CH*OW:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic exp_ri;
  logic exp_bank;

  wave_capture_multi #(
    .CHANNELS(CH), .SAMPLE_W(SW), .OUT_W(OW), .DEPTH_LOG2(DL)
  ) dut (
    .clk(clk), .reset(reset), .new_sample(new_sample), .sample(sample),
    .decim(decim), .trig_ch(trig_ch), .trig_mode(trig_mode),
    .wave_display_idle(wave_display_idle), .write_enable(write_enable),
    .write_address(write_address), .write_sample(write_sample),
    .read_index(read_index), .frame_done(frame_done), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_byte(input logic signed [15:0] s);
    logic signed [15:0] t;
    t = (s >>> 8) + 16'sd128;
    return t[7:0];
  endfunction

  function automatic logic signed [15:0] rnd16();
    return 16'($urandom_range(0, 65535));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one strobe per record, expected writes pushed as they are driven
  task automatic run_vecs(input int n);
    for (int i = 0; i < n; i++) begin
      new_sample = 1'b1;
      sample     = {vec[i].ch1, vec[i].ch0};
      if (vec[i].wr)
        exp_q.push_back({exp_bank, vec[i].idx, to_byte(vec[i].ch1), to_byte(vec[i].ch0)});
      tick();
    end
    new_sample = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset  = 1'b1;
    exp_ri   = 1'b0;
    exp_bank = 1'b1;
  endtask

  // Called right after the last write of a frame, with idle held high.
  task automatic expect_swap();
    @(negedge clk);
    chk("wait_state", 32'(state), 32'd2);
    chk("ri_before_swap", 32'(read_index), 32'(exp_ri));
    tick();
    @(negedge clk);
    exp_ri   = ~exp_ri;
    exp_bank = ~exp_ri;
    chk("ri_after_swap", 32'(read_index), 32'(exp_ri));
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("armed_after_swap", 32'(state), 32'd0);
    chk("bank_after_swap", 32'(write_address[DL]), 32'(exp_bank));
    tick();
    @(negedge clk);
    chk("frame_done_clear", 32'(frame_done), 32'd0);
    tick();
  endtask

  initial begin
    logic [DL+CH*OW:0] e;
    reset = 1'b0;
    new_sample = 1'b0;
    sample = '0;
    decim = 3'd0;
    trig_ch = 1'b0;
    trig_mode = 2'd0;
    wave_display_idle = 1'b1;
    exp_ri = 1'b0;
    exp_bank = 1'b1;

    // scoreboard monitor
    fork
      forever begin
        @(negedge clk);
        if (reset === 1'b1 && write_enable === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h, required no write at %0t",
                     write_address, write_sample, $time);
          end else begin
            e = exp_q.pop_front();
            chk("write", 32'({write_address, write_sample}), 32'(e));
          end
        end
      end
    join_none

    // reset values
    #12;
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_addr", 32'(write_address), 32'd16);
    chk("rst_sample", 32'(write_sample), 32'd0);
    chk("rst_ri", 32'(read_index), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // free-run, two frames: bank 1 then bank 0
    for (int k = 0; k < 16; k++)
      vec[k] = '{ch0: 16'(k * 256), ch1: 16'(-k * 256), wr: 1'b1, idx: DL'(k)};
    run_vecs(16);
    expect_swap();
    run_vecs(16);
    expect_swap();

    // rising zero-cross on ch0
    trig_mode = 2'd1;
    vec[0] = '{ch0: -16'sd512, ch1: 16'sd100, wr: 1'b0, idx: '0};
    vec[1] = '{ch0: -16'sd256, ch1: 16'sd100, wr: 1'b0, idx: '0};
    vec[2] = '{ch0: 16'sd256,  ch1: -16'sd300, wr: 1'b1, idx: '0};
    for (int k = 3; k < 18; k++)
      vec[k] = '{ch0: rnd16(), ch1: rnd16(), wr: 1'b1, idx: DL'(k - 2)};
    run_vecs(18);
    expect_swap();

    // falling cross on ch1, decim=2: only every 4th strobe counts
    trig_mode = 2'd2;
    trig_ch   = 1'b1;
    decim     = 3'd2;
    for (int j = 0; j < 69; j++) begin
      int a;
      a = j / 4;
      if (j % 4 != 0) begin
        vec[j] = '{ch0: rnd16(), ch1: -16'sd3000, wr: 1'b0, idx: '0};
      end else if (a < 2) begin
        vec[j] = '{ch0: (a == 1) ? -16'sd1000 : 16'sd1000, ch1: 16'(1000 * (a + 1)),
                   wr: 1'b0, idx: '0};
      end else if (a == 2) begin
        vec[j] = '{ch0: 16'sd500, ch1: -16'sd1280, wr: 1'b1, idx: '0};
      end else begin
        vec[j] = '{ch0: rnd16(), ch1: rnd16(), wr: 1'b1, idx: DL'(a - 2)};
      end
    end
    run_vecs(69);
    expect_swap();

    // swap held off while the display scans; strobes in WAIT are dropped
    decim = 3'd0;
    trig_ch = 1'b0;
    trig_mode = 2'd0;
    do_reset();
    wave_display_idle = 1'b0;
    for (int k = 0; k < 16; k++)
      vec[k] = '{ch0: rnd16(), ch1: rnd16(), wr: 1'b1, idx: DL'(k)};
    run_vecs(16);
    for (int c = 0; c < 50; c++) begin
      new_sample = 1'b1;
      sample = {rnd16(), rnd16()};
      @(negedge clk);
      chk("hold_state", 32'(state), 32'd2);
      chk("hold_ri", 32'(read_index), 32'd0);
      tick();
    end
    wave_display_idle = 1'b1;
    sample = {16'sd1000, 16'sd2000};
    tick();
    new_sample = 1'b0;
    @(negedge clk);
    chk("idle_toggle_ri", 32'(read_index), 32'd1);
    chk("idle_toggle_fd", 32'(frame_done), 32'd1);
    chk("idle_toggle_state", 32'(state), 32'd0);
    exp_ri = 1'b1;
    exp_bank = 1'b0;
    tick();
    vec[0] = '{ch0: 16'sd768, ch1: -16'sd768, wr: 1'b1, idx: '0};
    run_vecs(1);
    @(negedge clk);
    chk("post_swap_active", 32'(state), 32'd1);
    tick();

    // freeze: no writes in mode 3
    do_reset();
    trig_mode = 2'd3;
    for (int k = 0; k < 100; k++)
      vec[k % 80] = '{ch0: (k % 2) ? -16'sd4000 : 16'sd4000, ch1: rnd16(), wr: 1'b0, idx: '0};
    run_vecs(80);
    run_vecs(20);
    @(negedge clk);
    chk("freeze_state", 32'(state), 32'd0);
    tick();

    // asynchronous reset mid-capture at index 7
    trig_mode = 2'd0;
    for (int k = 0; k < 8; k++)
      vec[k] = '{ch0: rnd16(), ch1: rnd16(), wr: 1'b1, idx: DL'(k)};
    run_vecs(8);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("async_we", 32'(write_enable), 32'd0);
    chk("async_addr", 32'(write_address), 32'd16);
    chk("async_sample", 32'(write_sample), 32'd0);
    chk("async_ri", 32'(read_index), 32'd0);
    chk("async_fd", 32'(frame_done), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    exp_ri = 1'b0;
    exp_bank = 1'b1;
    vec[0] = '{ch0: -16'sd256, ch1: 16'sd256, wr: 1'b1, idx: '0};
    run_vecs(1);
    @(negedge clk);
    chk("restart_active", 32'(state), 32'd1);
    tick();

    // first accepted sample after reset never triggers
    do_reset();
    trig_mode = 2'd2;
    vec[0] = '{ch0: -16'sd256, ch1: 16'sd0, wr: 1'b0, idx: '0};
    vec[1] = '{ch0: 16'sd256,  ch1: 16'sd0, wr: 1'b0, idx: '0};
    vec[2] = '{ch0: -16'sd512, ch1: 16'sd0, wr: 1'b1, idx: '0};
    run_vecs(3);
    @(negedge clk);
    chk("falling_active", 32'(state), 32'd1);
    tick();
    tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
